// File: rtl/rewrite_run_pkg.sv
// Shared types for the run-length detector: per-channel FSM states and mode encodings.
package rewrite_run_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2,
        OVER = 2'd3
    } run_state_t;

    localparam logic MODE_EXACT   = 1'b0;
    localparam logic MODE_ATLEAST = 1'b1;

endpackage

// File: rtl/rewrite_run_chan.sv
// One detector channel: run-length Moore FSM, run counter and the registered hit pulse.
module rewrite_run_chan
    import rewrite_run_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clear,
    input  logic             in,
    input  logic [CNT_W-1:0] thresh,
    input  logic             mode,
    output logic             out,
    output logic             hit_pulse,
    output logic             enter_hit
);

    run_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W:0]   cnt_inc;

    // One extra bit so the threshold compare cannot wrap.
    assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        enter_hit = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (en) begin
            if (thresh == '0 || !in) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = (thresh == CNT_W'(1)) ? HIT : RUN;
                    end
                    // >= rather than == so a threshold lowered mid-run still terminates the run.
                    RUN: begin
                        cnt_nxt   = cnt_inc[CNT_W-1:0];
                        state_nxt = (cnt_inc >= {1'b0, thresh}) ? HIT : RUN;
                    end
                    HIT:     state_nxt = (mode == MODE_EXACT) ? OVER : HIT;
                    OVER:    state_nxt = (mode == MODE_ATLEAST) ? HIT : OVER;
                    default: state_nxt = IDLE;
                endcase
            end
        end
        enter_hit = (state_nxt == HIT) && (state != HIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            hit_pulse <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            hit_pulse <= enter_hit;
        end
    end

    assign out = (state == HIT);

endmodule

// File: rtl/rewrite_run_detector.sv
// Multi-channel run-length detector: NCH channel FSMs plus a saturating count of HIT entries.
module rewrite_run_detector
    import rewrite_run_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CNT_W = 4,
    parameter int HC_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clear,
    input  logic [NCH-1:0]   in,
    input  logic [CNT_W-1:0] thresh,
    input  logic             mode,
    output logic [NCH-1:0]   out,
    output logic [NCH-1:0]   hit_pulse,
    output logic [HC_W-1:0]  hit_count
);

    localparam int PC_W  = $clog2(NCH + 1);
    localparam int SUM_W = ((HC_W > PC_W) ? HC_W : PC_W) + 1;
    localparam logic [HC_W-1:0] HC_MAX = {HC_W{1'b1}};

    logic [NCH-1:0]  enter_hit;
    logic [PC_W-1:0] hit_pop;
    logic [SUM_W-1:0] hit_sum;
    logic [HC_W-1:0] hit_count_nxt;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        rewrite_run_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .clear     (clear),
            .in        (in[g]),
            .thresh    (thresh),
            .mode      (mode),
            .out       (out[g]),
            .hit_pulse (hit_pulse[g]),
            .enter_hit (enter_hit[g])
        );
    end

    // Sum is wide enough to hold max count plus a full popcount, so saturation is a plain compare.
    always_comb begin
        hit_pop = '0;
        for (int i = 0; i < NCH; i++) begin
            hit_pop = hit_pop + PC_W'(enter_hit[i]);
        end
        hit_sum       = SUM_W'(hit_count) + SUM_W'(hit_pop);
        hit_count_nxt = (hit_sum > SUM_W'(HC_MAX)) ? HC_MAX : hit_sum[HC_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count <= '0;
        end else if (clear) begin
            hit_count <= '0;
        end else if (en) begin
            hit_count <= hit_count_nxt;
        end
    end

endmodule

// File: tb/tb_rewrite_run_detector.sv
// Directed bench for rewrite_run_detector: run-length model checked every cycle plus pinned literals.
module tb_rewrite_run_detector;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        clear;
    logic [3:0]  in_v;
    logic [3:0]  thresh;
    logic        mode;

    logic [3:0]  out_m, pulse_m;
    logic [15:0] count_m;
    logic [3:0]  out_s, pulse_s;
    logic [1:0]  count_s;
    logic [0:0]  out_1, pulse_1;
    logic [15:0] count_1;

    int n_checks = 0;
    int n_pass   = 0;

    rewrite_run_detector #(.NCH(4), .CNT_W(4), .HC_W(16)) dut_main (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .in(in_v), .thresh(thresh),
        .mode(mode), .out(out_m), .hit_pulse(pulse_m), .hit_count(count_m)
    );

    rewrite_run_detector #(.NCH(4), .CNT_W(4), .HC_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .in(in_v), .thresh(thresh),
        .mode(mode), .out(out_s), .hit_pulse(pulse_s), .hit_count(count_s)
    );

    rewrite_run_detector #(.NCH(1), .CNT_W(4), .HC_W(16)) dut_one (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .in(in_v[0]), .thresh(thresh),
        .mode(mode), .out(out_1), .hit_pulse(pulse_1), .hit_count(count_1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: outputs follow from the length of the current run of sampled 1s.
    int         run_len [4];
    int         n_run   [4];
    logic [3:0] m_out, n_out, m_pulse, n_pulse;
    int         cm, cs, c1, n_cm, n_cs, n_c1, hits;

    always_comb begin
        n_run   = run_len;
        n_out   = m_out;
        n_pulse = '0;
        n_cm    = cm;
        n_cs    = cs;
        n_c1    = c1;
        hits    = 0;
        if (clear) begin
            n_run = '{default: 0};
            n_out = '0;
            n_cm  = 0;
            n_cs  = 0;
            n_c1  = 0;
        end else if (en) begin
            for (int i = 0; i < 4; i++) begin
                n_run[i]   = (thresh == 0 || !in_v[i]) ? 0 : run_len[i] + 1;
                n_out[i]   = (thresh != 0) &&
                             (mode ? (n_run[i] >= int'(thresh)) : (n_run[i] == int'(thresh)));
                n_pulse[i] = n_out[i] && !m_out[i];
                hits       = hits + int'(n_pulse[i]);
            end
            n_cm = (cm + hits > 65535) ? 65535 : cm + hits;
            n_cs = (cs + hits > 3) ? 3 : cs + hits;
            n_c1 = c1 + int'(n_pulse[0]);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_len <= '{default: 0};
            m_out   <= '0;
            m_pulse <= '0;
            cm      <= 0;
            cs      <= 0;
            c1      <= 0;
        end else begin
            run_len <= n_run;
            m_out   <= n_out;
            m_pulse <= n_pulse;
            cm      <= n_cm;
            cs      <= n_cs;
            c1      <= n_c1;
        end
    end

    always @(negedge clk) begin
        check("main_out",   32'(out_m),   32'(m_out));
        check("main_pulse", 32'(pulse_m), 32'(m_pulse));
        check("main_count", 32'(count_m), 32'(cm));
        check("sat_out",    32'(out_s),   32'(m_out));
        check("sat_pulse",  32'(pulse_s), 32'(m_pulse));
        check("sat_count",  32'(count_s), 32'(cs));
        check("one_out",    32'(out_1),   32'(m_out[0]));
        check("one_pulse",  32'(pulse_1), 32'(m_pulse[0]));
        check("one_count",  32'(count_1), 32'(c1));
    end

    // Drive one sampled edge; returns on the following falling edge.
    task automatic step(input logic [3:0] i, input logic e = 1'b1, input logic c = 1'b0);
        in_v  = i;
        en    = e;
        clear = c;
        @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b1;
        clear  = 1'b0;
        in_v   = '0;
        thresh = 4'd2;
        mode   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out", 32'(out_m), 32'h0);
        check("rst_count", 32'(count_m), 32'h0);
        rst_n = 1'b1;

        // Legacy two-ones sequence on a single channel.
        step(4'b0001);
        check("leg_after_1st", 32'(out_1), 32'h0);
        step(4'b0001);
        check("leg_out", 32'(out_1), 32'h1);
        check("leg_pulse", 32'(pulse_1), 32'h1);
        step(4'b0001);
        check("leg_over", 32'(out_1), 32'h0);
        step(4'b0000);
        check("leg_count", 32'(count_1), 32'd1);

        // ATLEAST, thresh 3, five ones.
        mode   = 1'b1;
        thresh = 4'd3;
        step(4'b0001);
        step(4'b0001);
        step(4'b0001);
        check("atl_3rd", 32'(out_m), 32'b0001);
        step(4'b0001);
        step(4'b0001);
        check("atl_5th", 32'(out_m), 32'b0001);
        step(4'b0000);
        check("atl_drop", 32'(out_m), 32'h0);
        check("atl_count", 32'(count_m), 32'd2);

        // thresh 0 disables detection.
        thresh = 4'd0;
        repeat (20) step(4'b1111);
        check("t0_out", 32'(out_m), 32'h0);
        check("t0_count", 32'(count_m), 32'd2);
        step(4'b0000);

        // Largest threshold, EXACT.
        mode   = 1'b0;
        thresh = 4'd15;
        repeat (14) step(4'b0001);
        check("t15_14th", 32'(out_m), 32'h0);
        step(4'b0001);
        check("t15_out", 32'(out_m), 32'b0001);
        check("t15_pulse", 32'(pulse_m), 32'b0001);
        step(4'b0001);
        check("t15_over", 32'(out_m), 32'h0);
        step(4'b0000);
        check("t15_count", 32'(count_m), 32'd3);

        // thresh 1: each 1 sampled from IDLE hits.
        thresh = 4'd1;
        step(4'b0001); check("t1_a", 32'(out_m), 32'b0001);
        step(4'b0000); check("t1_b", 32'(out_m), 32'b0000);
        step(4'b0001); check("t1_c", 32'(out_m), 32'b0001);
        step(4'b0001); check("t1_d", 32'(out_m), 32'b0000);
        step(4'b0000);
        step(4'b0001); check("t1_e", 32'(out_m), 32'b0001);
        step(4'b0000);
        check("t1_count", 32'(count_m), 32'd6);

        step(4'b0000, 1'b1, 1'b1);
        check("clr_main", 32'(count_m), 32'h0);
        check("clr_sat", 32'(count_s), 32'h0);

        // Simultaneous hits and counter saturation.
        thresh = 4'd2;
        step(4'b1011);
        step(4'b1011);
        check("multi_pulse", 32'(pulse_m), 32'b1011);
        check("multi_count", 32'(count_m), 32'd3);
        step(4'b0000);
        step(4'b1011);
        step(4'b1011);
        check("multi_count2", 32'(count_m), 32'd6);
        check("sat_count3", 32'(count_s), 32'd3);
        check("one_count2", 32'(count_1), 32'd2);
        step(4'b0000);

        // en low mid-run preserves the count.
        thresh = 4'd4;
        step(4'b0010);
        step(4'b0010);
        repeat (3) step(4'b0000, 1'b0);
        check("hold_out", 32'(out_m), 32'h0);
        step(4'b0010);
        check("hold_3rd", 32'(out_m), 32'h0);
        step(4'b0010);
        check("hold_hit", 32'(out_m), 32'b0010);
        check("hold_count", 32'(count_m), 32'd7);
        step(4'b0000);

        // en low while in HIT: out holds, pulse drops.
        mode   = 1'b1;
        thresh = 4'd2;
        step(4'b0100);
        step(4'b0100);
        check("enhit_pulse", 32'(pulse_m), 32'b0100);
        step(4'b0100, 1'b0);
        check("enhit_out", 32'(out_m), 32'b0100);
        check("enhit_nopulse", 32'(pulse_m), 32'h0);
        step(4'b0100, 1'b0);
        step(4'b0000);
        check("enhit_count", 32'(count_m), 32'd8);

        // clear on the threshold edge wins.
        mode = 1'b0;
        step(4'b1111);
        step(4'b1111, 1'b1, 1'b1);
        check("clrhit_out", 32'(out_m), 32'h0);
        check("clrhit_pulse", 32'(pulse_m), 32'h0);
        check("clrhit_count", 32'(count_m), 32'h0);
        step(4'b0000);

        // Async reset while in HIT.
        mode   = 1'b1;
        thresh = 4'd1;
        step(4'b1111);
        check("rsthit_pre", 32'(out_m), 32'b1111);
        #2 rst_n = 1'b0;
        #1;
        check("rsthit_main", 32'(out_m), 32'h0);
        check("rsthit_sat", 32'(out_s), 32'h0);
        check("rsthit_one", 32'(out_1), 32'h0);
        check("rsthit_count", 32'(count_m), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0000);
        step(4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
